// File: rtl/fmap_snake_seq.sv
// fmap_snake_seq
// Streams a ROWS x COLS feature map out of a memory in a snake-like order.
// HEAD walks rows 0 and 1 together, column by column. BODY then walks the
// remaining rows, with even rows scanned right-to-left and odd rows scanned
// left-to-right. Each memory word holds CH_IN 8-bit channels. The beat is
// zero-extended to LANES bytes on the output stream.
//
// Optional feature (macro SNAKE_PAD_EN): the walk covers a (ROWS+2)x(COLS+2)
// grid with a one-pixel zero border. Border positions emit zero beats and do
// not read memory.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset (aborts a frame in progress)
//   start      one-cycle frame request (ignored while busy, except on done)
//   busy       frame in progress
//   done       one-cycle pulse after the final beat transfers
//   mem_rd     memory read strobe; mem_rdata is valid the following cycle
//   mem_addr   read address = row*COLS + col (0 when not reading)
//   mem_rdata  read data, CH_IN bytes, channel 0 in [7:0]
//   out_data   output beat, mem_rdata zero-extended to LANES bytes
//   out_valid  output beat available
//   out_ready  downstream accepts a beat when high together with out_valid
module fmap_snake_seq #(
  parameter int ROWS   = 128,
  parameter int COLS   = 128,
  parameter int CH_IN  = 4,
  parameter int LANES  = 32,
  parameter int ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [CH_IN*8-1:0]   mem_rdata,
  output logic [LANES*8-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // state | meaning
  // IDLE  | waiting for start
  // HEAD  | rows 0 and 1 interleaved, column by column
  // BODY  | rows 2..last: even rows right-to-left, odd rows left-to-right
  // DRAIN | every beat issued; waiting for read pipe and FIFO to empty

`ifdef SNAKE_PAD_EN
  localparam int GR = ROWS + 2;
  localparam int GC = COLS + 2;
`else
  localparam int GR = ROWS;
  localparam int GC = COLS;
`endif
  localparam int RW = (GR > 1) ? $clog2(GR) : 1;
  localparam int CW = (GC > 1) ? $clog2(GC) : 1;
  localparam int DW = CH_IN * 8;
  localparam int OW = LANES * 8;
  localparam logic [RW-1:0] ROW_LAST = RW'(GR - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(GC - 1);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, DRAIN} state_t;

  state_t            state, state_n;
  logic [RW-1:0]     row, row_n;
  logic [CW-1:0]     col, col_n;
  logic              inflight;
  logic [DW-1:0]     fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              fifo_empty;
  logic              issue;
  logic              xfer, push, pop;
  logic [DW-1:0]     in_data;
  logic [DW-1:0]     beat;
  logic [ADDR_W-1:0] lin_addr;

  // A slot is issued only if FIFO entries plus the read in flight leave room,
  // so every returning word always has a FIFO entry waiting for it.
  assign issue = ((state == HEAD) || (state == BODY)) &&
                 ((fifo_cnt + 2'(inflight)) < 2'd2);

`ifdef SNAKE_PAD_EN
  logic border;
  logic inflight_pad;

  assign border   = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign lin_addr = ADDR_W'((int'(row) - 1) * COLS + int'(col) - 1);
  assign mem_rd   = issue && !border;
  assign in_data  = inflight_pad ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_pad <= 1'b0;
    else     inflight_pad <= issue && border;
  end
`else
  assign lin_addr = ADDR_W'(int'(row) * COLS + int'(col));
  assign mem_rd   = issue;
  assign in_data  = mem_rdata;
`endif

  assign mem_addr = mem_rd ? lin_addr : '0;

  // The word returning this cycle bypasses the FIFO when it is empty. This
  // keeps first out_valid two cycles after start with no extra latency.
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign out_valid  = !fifo_empty || inflight;
  assign beat       = !fifo_empty ? fifo_mem[rd_ptr] : (inflight ? in_data : '0);
  assign out_data   = OW'(beat);
  assign xfer       = out_valid && out_ready;
  assign pop        = xfer && !fifo_empty;
  assign push       = inflight && !(xfer && fifo_empty);

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && fifo_empty && !inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = HEAD;
          row_n   = '0;
          col_n   = '0;
        end
      end
      HEAD: begin
        if (issue) begin
          if (row == '0) begin
            row_n = RW'(1);
          end else if (col == COL_LAST) begin
            if (GR == 2) begin
              state_n = DRAIN;
              row_n   = '0;
              col_n   = '0;
            end else begin
              // Row 2 is even, so BODY starts at the right-hand edge.
              state_n = BODY;
              row_n   = RW'(2);
              col_n   = COL_LAST;
            end
          end else begin
            row_n = '0;
            col_n = col + CW'(1);
          end
        end
      end
      BODY: begin
        if (issue) begin
          if ((!row[0] && (col == '0)) || (row[0] && (col == COL_LAST))) begin
            if (row == ROW_LAST) begin
              state_n = DRAIN;
              row_n   = '0;
              col_n   = '0;
            end else begin
              row_n = row + RW'(1);
              col_n = row[0] ? COL_LAST : '0;
            end
          end else begin
            col_n = row[0] ? (col + CW'(1)) : (col - CW'(1));
          end
        end
      end
      DRAIN: begin
        if (done) state_n = start ? HEAD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      inflight <= issue;
      if (push) begin
        fifo_mem[wr_ptr] <= in_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fmap_snake_seq.sv
// Directed testbench for fmap_snake_seq. It uses a small grid: 4x3 in the
// default build and 2x2 with SNAKE_PAD_EN defined. A one-cycle-latency
// memory model feeds the DUT. A monitor logs reads, transfers and done pulses
// with cycle stamps, and each test task compares that log to hand-computed
// values.
`timescale 1ns/1ps
module tb_fmap_snake_seq;
`ifdef SNAKE_PAD_EN
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int NB   = 16;
`else
  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int NB   = 12;
`endif
  localparam int CH_IN  = 4;
  localparam int LANES  = 32;
  localparam int ADDR_W = 14;
  localparam int DW     = CH_IN * 8;
  localparam int OW     = LANES * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, done, mem_rd, out_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_rdata = '0;
  logic [OW-1:0]     out_data;

  int n_checks = 0;
  int n_fail   = 0;

  int            cyc = 0;
  int            outst = 0;
  int            max_out = 0;
  int            rd_addr_q[$];
  int            rd_cyc_q[$];
  logic [OW-1:0] beat_q[$];
  int            beat_cyc_q[$];
  int            done_cyc_q[$];

`ifdef SNAKE_PAD_EN
  int exp_rd   [4]  = '{0, 1, 3, 2};
  int exp_beat [16] = '{0, 0, 0, 1, 0, 2, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0};
`else
  int exp_addr [12] = '{0, 3, 1, 4, 2, 5, 8, 7, 6, 9, 10, 11};
`endif

  fmap_snake_seq #(
    .ROWS(ROWS), .COLS(COLS), .CH_IN(CH_IN), .LANES(LANES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int a);
`ifdef SNAKE_PAD_EN
    return DW'(a + 1);
`else
    return {16'hC35A, 16'(a + 1)};
`endif
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= word(int'(mem_addr));
  end

  always @(negedge clk) begin
    int o;
    if (rst) begin
      outst <= 0;
    end else begin
      o = outst;
      if (mem_rd) begin
        rd_addr_q.push_back(int'(mem_addr));
        rd_cyc_q.push_back(cyc);
        o = o + 1;
      end
      if (out_valid && out_ready) begin
        beat_q.push_back(out_data);
        beat_cyc_q.push_back(cyc);
        o = o - 1;
      end
      if (done) done_cyc_q.push_back(cyc);
      outst <= o;
      if (o > max_out) max_out <= o;
    end
  end

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (mem_rd !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (mem_addr !== '0)    begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

`ifdef SNAKE_PAD_EN
  task automatic test_pad(input string tag);
    int rb, bb, db, sc, n;
    logic [OW-1:0] exp;
    rb = rd_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
    out_ready = 1'b1;
    start = 1'b1; sc = cyc;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done_cyc_q.size() == db && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (done_cyc_q.size() == db) begin n_fail++; $display("FAIL %s_done_timeout: no done in 200 cycles", tag); end
    n_checks++;
    if (rd_addr_q.size() - rb != 4) begin n_fail++; $display("FAIL %s_rd_count: got %0d expected 4", tag, rd_addr_q.size() - rb); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rb + i >= rd_addr_q.size() || rd_addr_q[rb+i] != exp_rd[i]) begin
        n_fail++;
        $display("FAIL %s_rd_addr[%0d]: got %0d expected %0d", tag, i, (rb + i < rd_addr_q.size()) ? rd_addr_q[rb+i] : -1, exp_rd[i]);
      end
    end
    n_checks++;
    if (beat_q.size() - bb != NB) begin n_fail++; $display("FAIL %s_beat_count: got %0d expected %0d", tag, beat_q.size() - bb, NB); end
    for (int i = 0; i < NB; i++) begin
      exp = OW'(exp_beat[i]);
      n_checks++;
      if (bb + i >= beat_q.size() || beat_q[bb+i] !== exp) begin
        n_fail++;
        $display("FAIL %s_beat[%0d]: got %h expected %h", tag, i, (bb + i < beat_q.size()) ? beat_q[bb+i] : '1, exp);
      end
    end
    n_checks++;
    if (bb >= beat_cyc_q.size() || beat_cyc_q[bb] != sc + 2) begin n_fail++; $display("FAIL %s_first_valid: expected cycle %0d", tag, sc + 2); end
    n_checks++;
    if (db >= done_cyc_q.size() || done_cyc_q[db] != sc + NB + 2) begin n_fail++; $display("FAIL %s_done_cycle: expected cycle %0d", tag, sc + NB + 2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b expected 0", tag, busy); end
  endtask
`else
  task automatic test_basic();
    int rb, bb, db, sc, n;
    logic [OW-1:0] exp;
    rb = rd_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
    out_ready = 1'b1;
    start = 1'b1; sc = cyc;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done_cyc_q.size() == db && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (done_cyc_q.size() == db) begin n_fail++; $display("FAIL basic_done_timeout: no done in 200 cycles"); end
    n_checks++;
    if (rd_addr_q.size() - rb != NB) begin n_fail++; $display("FAIL basic_rd_count: got %0d expected %0d", rd_addr_q.size() - rb, NB); end
    for (int i = 0; i < NB; i++) begin
      n_checks++;
      if (rb + i >= rd_addr_q.size() || rd_addr_q[rb+i] != exp_addr[i]) begin
        n_fail++;
        $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, (rb + i < rd_addr_q.size()) ? rd_addr_q[rb+i] : -1, exp_addr[i]);
      end
    end
    n_checks++;
    if (beat_q.size() - bb != NB) begin n_fail++; $display("FAIL basic_beat_count: got %0d expected %0d", beat_q.size() - bb, NB); end
    for (int i = 0; i < NB; i++) begin
      exp = OW'(word(exp_addr[i]));
      n_checks++;
      if (bb + i >= beat_q.size() || beat_q[bb+i] !== exp) begin
        n_fail++;
        $display("FAIL basic_beat[%0d]: got %h expected %h", i, (bb + i < beat_q.size()) ? beat_q[bb+i] : '1, exp);
      end
    end
    n_checks++;
    if (rb >= rd_cyc_q.size() || rd_cyc_q[rb] != sc + 1) begin n_fail++; $display("FAIL basic_first_rd: expected cycle %0d", sc + 1); end
    n_checks++;
    if (bb >= beat_cyc_q.size() || beat_cyc_q[bb] != sc + 2) begin n_fail++; $display("FAIL basic_first_valid: expected cycle %0d", sc + 2); end
    n_checks++;
    if (bb + NB - 1 >= beat_cyc_q.size() || beat_cyc_q[bb+NB-1] != sc + NB + 1) begin n_fail++; $display("FAIL basic_last_beat: expected cycle %0d", sc + NB + 1); end
    n_checks++;
    if (db >= done_cyc_q.size() || done_cyc_q[db] != sc + NB + 2) begin n_fail++; $display("FAIL basic_done_cycle: expected cycle %0d", sc + NB + 2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_stall();
    int rb, bb, db, sc, n;
    logic [OW-1:0] held, exp;
    rb = rd_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
    out_ready = 1'b1;
    start = 1'b1; sc = cyc;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (beat_q.size() - bb < 4 && n < 50) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (beat_q.size() - bb != 4) begin n_fail++; $display("FAIL stall_beat4: got %0d beats expected 4", beat_q.size() - bb); end
    out_ready = 1'b0;
    held = out_data;
    exp  = OW'(word(exp_addr[4]));
    n_checks++; if (held !== exp) begin n_fail++; $display("FAIL stall_head: got %h expected %h", held, exp); end
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid %b data %h expected 1 %h", k, out_valid, out_data, exp);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (done_cyc_q.size() == db && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (done_cyc_q.size() == db) begin n_fail++; $display("FAIL stall_done_timeout: no done in 200 cycles"); end
    n_checks++;
    if (rd_addr_q.size() - rb != NB) begin n_fail++; $display("FAIL stall_rd_count: got %0d expected %0d", rd_addr_q.size() - rb, NB); end
    n_checks++;
    if (beat_q.size() - bb != NB) begin n_fail++; $display("FAIL stall_beat_count: got %0d expected %0d", beat_q.size() - bb, NB); end
    for (int i = 0; i < NB; i++) begin
      exp = OW'(word(exp_addr[i]));
      n_checks++;
      if (rb + i >= rd_addr_q.size() || rd_addr_q[rb+i] != exp_addr[i] || bb + i >= beat_q.size() || beat_q[bb+i] !== exp) begin
        n_fail++; $display("FAIL stall_seq[%0d]: expected addr %0d data %h", i, exp_addr[i], exp);
      end
    end
    n_checks++;
    if (max_out > 2) begin n_fail++; $display("FAIL stall_outstanding: got %0d expected at most 2", max_out); end
    n_checks++;
    if (db >= done_cyc_q.size() || done_cyc_q[db] != sc + NB + 7) begin n_fail++; $display("FAIL stall_done_cycle: expected cycle %0d", sc + NB + 7); end
  endtask

  task automatic test_reset_abort();
    int rb, bb, db, sc, n;
    logic [OW-1:0] exp;
    bb = beat_q.size();
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (beat_q.size() - bb < 6 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_rd !== 1'b0 || out_valid !== 1'b0 || mem_addr !== '0 || out_data !== '0) begin
      n_fail++; $display("FAIL abort_outputs_in_reset: busy %b done %b rd %b valid %b addr %h expected all 0", busy, done, mem_rd, out_valid, mem_addr);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || mem_rd !== 1'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL abort_outputs_held: valid %b rd %b expected 0", out_valid, mem_rd);
    end
    rst = 1'b0;
    rb = rd_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (beat_q.size() != bb || rd_addr_q.size() != rb || done_cyc_q.size() != db || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_residue: beats %0d reads %0d busy %b expected 0 0 0", beat_q.size() - bb, rd_addr_q.size() - rb, busy);
    end
    start = 1'b1; sc = cyc;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done_cyc_q.size() == db && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (done_cyc_q.size() == db) begin n_fail++; $display("FAIL abort_done_timeout: no done in 200 cycles"); end
    n_checks++;
    if (rb >= rd_cyc_q.size() || rd_cyc_q[rb] != sc + 1) begin n_fail++; $display("FAIL abort_first_rd: expected cycle %0d", sc + 1); end
    n_checks++;
    if (beat_q.size() - bb != NB) begin n_fail++; $display("FAIL abort_beat_count: got %0d expected %0d", beat_q.size() - bb, NB); end
    for (int i = 0; i < NB; i++) begin
      exp = OW'(word(exp_addr[i]));
      n_checks++;
      if (rb + i >= rd_addr_q.size() || rd_addr_q[rb+i] != exp_addr[i] || bb + i >= beat_q.size() || beat_q[bb+i] !== exp) begin
        n_fail++; $display("FAIL abort_seq[%0d]: expected addr %0d data %h", i, exp_addr[i], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rb, bb, db, sc, sc2, n;
    rb = rd_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
    out_ready = 1'b1;
    start = 1'b1; sc = cyc;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_mid: got %b expected 1", busy); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_timeout: no done in 200 cycles"); end
    n_checks++; if (cyc != sc + NB + 2) begin n_fail++; $display("FAIL b2b_first_done: got cycle %0d expected %0d", cyc, sc + NB + 2); end
    start = 1'b1; sc2 = cyc;
    @(posedge clk); #1; start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_after_done: got %b expected 1", busy); end
    n = 0;
    while (done_cyc_q.size() < db + 2 && n < 200) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (done_cyc_q.size() - db != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cyc_q.size() - db); end
    n_checks++;
    if (rd_addr_q.size() - rb != 2 * NB) begin n_fail++; $display("FAIL b2b_rd_count: got %0d expected %0d", rd_addr_q.size() - rb, 2 * NB); end
    for (int i = 0; i < 2 * NB; i++) begin
      n_checks++;
      if (rb + i >= rd_addr_q.size() || rd_addr_q[rb+i] != exp_addr[i % NB]) begin
        n_fail++;
        $display("FAIL b2b_addr[%0d]: got %0d expected %0d", i, (rb + i < rd_addr_q.size()) ? rd_addr_q[rb+i] : -1, exp_addr[i % NB]);
      end
    end
    n_checks++;
    if (rb + NB >= rd_cyc_q.size() || rd_cyc_q[rb+NB] != sc2 + 1) begin n_fail++; $display("FAIL b2b_second_rd: expected cycle %0d", sc2 + 1); end
    n_checks++;
    if (bb + NB >= beat_cyc_q.size() || beat_cyc_q[bb+NB] != sc2 + 2) begin n_fail++; $display("FAIL b2b_second_valid: expected cycle %0d", sc2 + 2); end
    n_checks++;
    if (beat_q.size() - bb != 2 * NB) begin n_fail++; $display("FAIL b2b_beat_count: got %0d expected %0d", beat_q.size() - bb, 2 * NB); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SNAKE_PAD_EN
    test_pad("pad");
    test_pad("pad_again");
`else
    test_basic();
    test_stall();
    test_reset_abort();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
